// File: rtl/i2c_slave_responder.sv
// -----------------------------------------------------------------------------
// i2c_slave_responder
//
// I2C target that answers one 7-bit address and serves a small byte-wide
// register file. SCL/SDA are oversampled on i2c_clk, START/STOP are detected
// from the synchronised pins, and the transfer is handled by one FSM.
// Protocol on the bus:
//   write: S, {addr,0}, ptr, data0, data1, ... P
//          (the pointer auto-increments after each data byte)
//   read : S, {addr,1}, data at ptr, data at ptr+1, ... (master NACKs last), P
// A repeated START may separate the pointer write from a read.
//
// Parameters
//   SLAVE_ADDR : 7-bit bus address answered by this target
//   PTR_W      : register pointer width; register file holds 2**PTR_W bytes
//
// Ports
//   i2c_clk   : single clock, at least 8x the SCL frequency
//   i2c_reset : synchronous, active-high reset
//   scl_in    : SCL pin level (asynchronous)
//   sda_in    : SDA pin level (asynchronous)
//   sda_oe    : 1 = pull SDA low (open-drain), 0 = release
//   wr_valid  : one-cycle pulse per data byte written from the bus
//   wr_addr   : register index of that write
//   wr_data   : byte written
//   rd_addr   : local read index (not bus related)
//   rd_data   : reg[rd_addr], combinational
//   busy      : high from address match until STOP or abort
// -----------------------------------------------------------------------------
module i2c_slave_responder #(
  parameter logic [6:0] SLAVE_ADDR = 7'h2A,
  parameter int         PTR_W      = 4
) (
  input  logic             i2c_clk,
  input  logic             i2c_reset,
  input  logic             scl_in,
  input  logic             sda_in,
  output logic             sda_oe,
  output logic             wr_valid,
  output logic [PTR_W-1:0] wr_addr,
  output logic [7:0]       wr_data,
  input  logic [PTR_W-1:0] rd_addr,
  output logic [7:0]       rd_data,
  output logic             busy
);

  localparam int DEPTH = 1 << PTR_W;

  typedef enum logic [3:0] {
    IDLE,
    ADDR,
    ADDR_ACK,
    PTR,
    PTR_ACK,
    WDATA,
    WACK,
    RDATA,
    RACK,
    WAIT_STOP
  } state_t;

  // ---------------------------------------------------------------------------
  // Pin synchronisers: two flops for metastability, a third as edge history.
  // All three reset to 1 (idle bus level) so reset never fakes an event.
  // ---------------------------------------------------------------------------
  logic scl_meta_q, scl_sync_q, scl_hist_q;
  logic sda_meta_q, sda_sync_q, sda_hist_q;

  always_ff @(posedge i2c_clk) begin
    if (i2c_reset) begin
      scl_meta_q <= 1'b1;
      scl_sync_q <= 1'b1;
      scl_hist_q <= 1'b1;
      sda_meta_q <= 1'b1;
      sda_sync_q <= 1'b1;
      sda_hist_q <= 1'b1;
    end else begin
      scl_meta_q <= scl_in;
      scl_sync_q <= scl_meta_q;
      scl_hist_q <= scl_sync_q;
      sda_meta_q <= sda_in;
      sda_sync_q <= sda_meta_q;
      sda_hist_q <= sda_sync_q;
    end
  end

  // Bus events. START/STOP require SCL high on both the current and the
  // previous sample so an SDA change coincident with an SCL edge is not
  // mistaken for a bus condition.
  logic scl_rise, scl_fall, start_det, stop_det;

  assign scl_rise  = scl_sync_q & ~scl_hist_q;
  assign scl_fall  = ~scl_sync_q & scl_hist_q;
  assign start_det = scl_sync_q & scl_hist_q & sda_hist_q & ~sda_sync_q;
  assign stop_det  = scl_sync_q & scl_hist_q & ~sda_hist_q & sda_sync_q;

  // ---------------------------------------------------------------------------
  // FSM state and datapath registers
  // ---------------------------------------------------------------------------
  state_t           state_q;
  logic [3:0]       bit_cnt_q;    // SCL rising edges seen in the current byte
  logic [7:0]       shift_q;      // receive shifter / transmit shifter
  logic [PTR_W-1:0] ptr_q;
  logic             rw_q;         // R/W bit of the matched address byte
  logic             ack_phase_q;  // ACK states: 1 once SDA is being pulled
                                  // RACK: 1 once the master ACKed
  logic             sda_oe_q;
  logic             busy_q;
  logic             wr_valid_q;
  logic [PTR_W-1:0] wr_addr_q;
  logic [7:0]       wr_data_q;
  logic [7:0]       regs_q [DEPTH];

  // Combinational helpers
  logic [7:0]       byte_d;       // shifter contents including the bit now sampled
  logic [PTR_W-1:0] ptr_inc_d;
  logic [7:0]       ptr_data_d;   // register addressed by the current pointer

  assign byte_d     = {shift_q[6:0], sda_sync_q};
  assign ptr_inc_d  = ptr_q + PTR_W'(1);
  assign ptr_data_d = regs_q[ptr_q];

  always_ff @(posedge i2c_clk) begin
    if (i2c_reset) begin
      state_q     <= IDLE;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      ptr_q       <= '0;
      rw_q        <= 1'b0;
      ack_phase_q <= 1'b0;
      sda_oe_q    <= 1'b0;
      busy_q      <= 1'b0;
      wr_valid_q  <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      wr_valid_q <= 1'b0;

      if (stop_det) begin
        // STOP ends everything immediately, including any byte in flight.
        state_q     <= IDLE;
        bit_cnt_q   <= '0;
        ack_phase_q <= 1'b0;
        sda_oe_q    <= 1'b0;
        busy_q      <= 1'b0;
      end else if (start_det) begin
        // START or repeated START: a partial byte is simply dropped.
        // SDA can only fall here if we are not pulling it, so sda_oe is
        // already 0; clearing it keeps the FSM self-consistent anyway.
        state_q     <= ADDR;
        bit_cnt_q   <= '0;
        ack_phase_q <= 1'b0;
        sda_oe_q    <= 1'b0;
      end else begin
        unique case (state_q)
          IDLE: begin
            // Only a START leaves IDLE.
          end

          ADDR: begin
            if (scl_rise) begin
              shift_q <= byte_d;
              if (bit_cnt_q == 4'd7) begin
                bit_cnt_q <= '0;
                if (byte_d[7:1] == SLAVE_ADDR) begin
                  rw_q        <= byte_d[0];
                  busy_q      <= 1'b1;
                  ack_phase_q <= 1'b0;
                  state_q     <= ADDR_ACK;
                end else begin
                  busy_q  <= 1'b0;
                  state_q <= WAIT_STOP;
                end
              end else begin
                bit_cnt_q <= bit_cnt_q + 4'd1;
              end
            end
          end

          // ACK slot: pull SDA on the fall after bit 8, release on the
          // fall after bit 9 and move on.
          ADDR_ACK, PTR_ACK, WACK: begin
            if (scl_fall) begin
              if (!ack_phase_q) begin
                sda_oe_q    <= 1'b1;
                ack_phase_q <= 1'b1;
              end else begin
                ack_phase_q <= 1'b0;
                bit_cnt_q   <= '0;
                if (state_q == ADDR_ACK && rw_q) begin
                  // The release edge of the ACK is also the edge that puts
                  // the first read bit on the bus.
                  sda_oe_q <= ~ptr_data_d[7];
                  shift_q  <= {ptr_data_d[6:0], 1'b0};
                  state_q  <= RDATA;
                end else begin
                  sda_oe_q <= 1'b0;
                  state_q  <= (state_q == ADDR_ACK) ? PTR : WDATA;
                end
              end
            end
          end

          PTR: begin
            if (scl_rise) begin
              shift_q <= byte_d;
              if (bit_cnt_q == 4'd7) begin
                bit_cnt_q   <= '0;
                ptr_q       <= byte_d[PTR_W-1:0];
                ack_phase_q <= 1'b0;
                state_q     <= PTR_ACK;
              end else begin
                bit_cnt_q <= bit_cnt_q + 4'd1;
              end
            end
          end

          WDATA: begin
            if (scl_rise) begin
              shift_q <= byte_d;
              if (bit_cnt_q == 4'd7) begin
                bit_cnt_q     <= '0;
                regs_q[ptr_q] <= byte_d;
                wr_valid_q    <= 1'b1;
                wr_addr_q     <= ptr_q;
                wr_data_q     <= byte_d;
                ptr_q         <= ptr_inc_d;
                ack_phase_q   <= 1'b0;
                state_q       <= WACK;
              end else begin
                bit_cnt_q <= bit_cnt_q + 4'd1;
              end
            end
          end

          RDATA: begin
            // Bit 7 was driven on entry; each fall drives the next bit until
            // the master has clocked in all 8, then SDA is released.
            if (scl_rise) begin
              bit_cnt_q <= bit_cnt_q + 4'd1;
            end else if (scl_fall) begin
              if (bit_cnt_q == 4'd8) begin
                sda_oe_q    <= 1'b0;
                bit_cnt_q   <= '0;
                ack_phase_q <= 1'b0;
                state_q     <= RACK;
              end else begin
                sda_oe_q <= ~shift_q[7];
                shift_q  <= {shift_q[6:0], 1'b0};
              end
            end
          end

          RACK: begin
            if (scl_rise) begin
              if (sda_sync_q) begin
                // Master NACK: the read is over, wait for STOP/START.
                state_q <= WAIT_STOP;
              end else begin
                ptr_q       <= ptr_inc_d;
                ack_phase_q <= 1'b1;
              end
            end else if (scl_fall && ack_phase_q) begin
              // Pointer already advanced on the ACK rise.
              ack_phase_q <= 1'b0;
              bit_cnt_q   <= '0;
              sda_oe_q    <= ~ptr_data_d[7];
              shift_q     <= {ptr_data_d[6:0], 1'b0};
              state_q     <= RDATA;
            end
          end

          WAIT_STOP: begin
            sda_oe_q <= 1'b0;
          end

          default: begin
            state_q  <= IDLE;
            sda_oe_q <= 1'b0;
          end
        endcase
      end
    end
  end

  // Local inspection port: reads the stored value, so a bus write in the
  // same cycle becomes visible one cycle later.
  assign rd_data  = regs_q[rd_addr];

  assign sda_oe   = sda_oe_q;
  assign busy     = busy_q;
  assign wr_valid = wr_valid_q;
  assign wr_addr  = wr_addr_q;
  assign wr_data  = wr_data_q;

endmodule
